// File: rtl/button_decoder.sv
// -----------------------------------------------------------------------------
// button_decoder
//
// Turns one raw, bouncing pushbutton pin into a clean debounced level plus
// single-cycle command pulses for the colour-sequencing logic:
//   - short_press : button released before the long-press threshold
//   - long_press  : button held for LONG_PRESS_CYCLES
//   - repeat_tick : every REPEAT_CYCLES while still held after long_press
//
// Pipeline: 2-flop synchroniser -> polarity normalise -> counter debouncer ->
// press-classification FSM (IDLE / PRESSED / HELD). All outputs are registered.
//
// Ports:
//   clk          in   system clock (12 MHz board clock)
//   rst_n        in   asynchronous active-low reset
//   btn_raw      in   raw asynchronous button pin
//   pressed      out  debounced level, 1 = button down
//   short_press  out  1-cycle pulse, release before the long-press threshold
//   long_press   out  1-cycle pulse, button held LONG_PRESS_CYCLES
//   repeat_tick  out  1-cycle pulse every REPEAT_CYCLES while held after
//                     long_press
//
// Parameter legal ranges: DEBOUNCE_CYCLES >= 1, LONG_PRESS_CYCLES > 1,
// REPEAT_CYCLES >= 1.
// -----------------------------------------------------------------------------
module button_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned LONG_PRESS_CYCLES = 6000000,
  parameter int unsigned REPEAT_CYCLES     = 2000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick
);

  // ---------------------------------------------------------------------------
  // Widths and terminal counts
  // ---------------------------------------------------------------------------
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(REPEAT_CYCLES - 1);

  // Pin level when the button is up; the synchroniser resets to it so that a
  // button already held at reset release is seen as a fresh edge.
  localparam logic RELEASED_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic btn_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RELEASED_LVL;
      sync2_q <= RELEASED_LVL;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Normalised: 1 means the button is down regardless of pin polarity.
  assign btn_s = sync2_q ^ RELEASED_LVL;

  // ---------------------------------------------------------------------------
  // Debouncer
  // db_cnt counts consecutive cycles in which btn_s disagrees with the
  // debounced level; any agreeing cycle restarts it.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            pressed_q;
  logic            pressed_d;

  always_comb begin
    db_cnt_d  = db_cnt_q;
    pressed_d = pressed_q;
    if (btn_s == pressed_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      pressed_d = btn_s;
      db_cnt_d  = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      pressed_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      pressed_q <= pressed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Press-classification FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q;
  logic [REP_W-1:0]  rep_cnt_d;
  logic              short_q;
  logic              short_d;
  logic              long_q;
  logic              long_d;
  logic              tick_q;
  logic              tick_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    tick_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pressed_q) begin
          state_d    = ST_PRESSED;
          // The cycle spent leaving IDLE already counts as held time, so
          // long_press lands exactly LONG_PRESS_CYCLES after pressed rises.
          hold_cnt_d = HOLD_FIRST;
        end
      end

      ST_PRESSED: begin
        // Release is tested first: a release coinciding with the threshold
        // still classifies as a short press.
        if (!pressed_q) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          long_d    = 1'b1;
          state_d   = ST_HELD;
          rep_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_HELD: begin
        if (!pressed_q) begin
          state_d = ST_IDLE;
        end else if (rep_cnt_q == REP_LAST) begin
          tick_d    = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      short_q    <= short_d;
      long_q     <= long_d;
      tick_q     <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pressed     = pressed_q;
  assign short_press = short_q;
  assign long_press  = long_q;
  assign repeat_tick = tick_q;

endmodule

// File: tb/tb_button_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_decoder
//
// Directed bench for button_decoder with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1.
// A behavioural model (sample history + debounce window + event timing since
// the last debounced rise) is compared against every output each cycle;
// directed sequences pin the model with hand-computed cycle counts.
// -----------------------------------------------------------------------------
module tb_button_decoder;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic btn_raw = 1'b0;
  logic pressed;
  logic short_press;
  logic long_press;
  logic repeat_tick;

  always #5 clk = ~clk;

  button_decoder #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .REPEAT_CYCLES     (REP),
    .ACTIVE_LOW        (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .pressed     (pressed),
    .short_press (short_press),
    .long_press  (long_press),
    .repeat_tick (repeat_tick)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model + per-cycle compare
  // ---------------------------------------------------------------------------
  logic raw_pos;  // pin value seen by the DUT at the latest rising edge
  always @(posedge clk) raw_pos <= btn_raw;

  initial begin : compare_proc
    bit sq[$];     // normalised samples still in flight through the synchroniser
    bit win[$];    // synchronised samples since the debounced level last changed
    bit m_pressed;
    bit p1;        // model pressed after the previous edge
    bit p2;        // model pressed two edges ago
    bit bs;
    bit all_diff;
    bit e_short;
    bit e_long;
    bit e_rep;
    int n;
    int rise_n;
    int age;

    sq = '{1'b0, 1'b0};
    win.delete();
    m_pressed = 1'b0; p1 = 1'b0; p2 = 1'b0; n = 0; rise_n = -1000;

    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sq = '{1'b0, 1'b0};
        win.delete();
        m_pressed = 1'b0; p1 = 1'b0; p2 = 1'b0; n = 0; rise_n = -1000;
        check("rst_pressed", pressed, 0);
        check("rst_short", short_press, 0);
        check("rst_long", long_press, 0);
        check("rst_repeat", repeat_tick, 0);
      end else begin
        n++;
        // Two-sample pipeline delay, pressed = pin low.
        bs = sq.pop_front();
        sq.push_back(!raw_pos);
        // Debounced level flips once DEB consecutive synchronised samples
        // all disagree with it.
        win.push_back(bs);
        if (win.size() > DEB) void'(win.pop_front());
        if (win.size() == DEB) begin
          all_diff = 1'b1;
          foreach (win[i]) if (win[i] == m_pressed) all_diff = 1'b0;
          if (all_diff) begin
            m_pressed = !m_pressed;
            win.delete();
          end
        end
        if (!p1 && m_pressed) rise_n = n;
        age     = n - rise_n;
        e_long  = p1 && (age == LONG);
        e_rep   = p1 && (age > LONG) && (((age - LONG) % REP) == 0);
        e_short = !p1 && p2 && ((n - 1 - rise_n) <= LONG - 1);
        check("cyc_pressed", pressed, m_pressed);
        check("cyc_short", short_press, e_short);
        check("cyc_long", long_press, e_long);
        check("cyc_repeat", repeat_tick, e_rep);
        p2 = p1;
        p1 = m_pressed;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver / observation tasks
  // ---------------------------------------------------------------------------
  int obs_sh, obs_lo, obs_rp, obs_pr, first_sh, first_lo;
  int rep_at[$];
  logic [7:0] exp_q[$];

  task automatic drive(input logic v);
    #1 btn_raw = v;
  endtask

  // Watch ncyc cycles; record pulse counts and the cycle index of each pulse.
  task automatic observe(input int ncyc);
    obs_sh = 0; obs_lo = 0; obs_rp = 0; obs_pr = 0;
    first_sh = -1; first_lo = -1;
    rep_at.delete();
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (pressed === 1'b1) obs_pr++;
      if (short_press === 1'b1) begin
        obs_sh++;
        if (first_sh < 0) first_sh = i;
      end
      if (long_press === 1'b1) begin
        obs_lo++;
        if (first_lo < 0) first_lo = i;
      end
      if (repeat_tick === 1'b1) begin
        obs_rp++;
        rep_at.push_back(i);
      end
    end
  endtask

  // Bounded wait for the debounced level; checks the cycle it arrives on.
  task automatic wait_level(input string name, input logic lvl, input int max,
                            input int exp);
    int found;
    found = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (pressed === lvl) begin
        found = i;
        break;
      end
    end
    check(name, found, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : main_proc
    int hi;

    // Reset with the button already held down.
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pressed", pressed, 0);
    check("reset_short", short_press, 0);
    #2 rst_n = 1'b1;
    wait_level("reset_release_rise", 1'b1, 12, 6);
    drive(1'b1);
    observe(20);
    check("reset_hold_short_cnt", obs_sh, 1);
    check("reset_hold_short_at", first_sh, 7);
    check("reset_hold_long_cnt", obs_lo, 0);

    // 3-cycle glitches while released.
    hi = 0;
    repeat (3) begin
      drive(1'b0); observe(3); hi += obs_pr;
      drive(1'b1); observe(6); hi += obs_pr;
    end
    check("glitch_pressed_cycles", hi, 0);

    // Bounce 1->0->1->0 with 2-cycle segments, then steady low.
    drive(1'b0); observe(2); hi = obs_pr;
    drive(1'b1); observe(2); hi += obs_pr;
    check("bounce_no_early", hi, 0);
    drive(1'b0);
    wait_level("bounce_rise", 1'b1, 12, 6);

    // Short press: pressed high for 10 cycles.
    observe(4);
    check("short_hold_long", obs_lo, 0);
    drive(1'b1);
    wait_level("short_fall", 1'b0, 12, 6);
    observe(5);
    check("short_at", first_sh, 1);
    check("short_cnt", obs_sh, 1);
    check("short_long_cnt", obs_lo, 0);
    check("short_rep_cnt", obs_rp, 0);

    // Long press with repeats over 60 cycles.
    drive(1'b0);
    wait_level("long_rise", 1'b1, 12, 6);
    observe(60);
    check("long_at", first_lo, 20);
    check("long_cnt", obs_lo, 1);
    check("long_short_cnt", obs_sh, 0);
    exp_q = '{8'd28, 8'd36, 8'd44, 8'd52, 8'd60};
    check("rep_cnt", rep_at.size(), exp_q.size());
    foreach (exp_q[i])
      check("rep_at", (i < rep_at.size()) ? rep_at[i] : -1, exp_q[i]);
    drive(1'b1);
    observe(15);
    check("long_release_short", obs_sh, 0);
    check("long_release_rep", obs_rp, 0);

    // Boundary: pressed falls on the last cycle before the threshold.
    drive(1'b0);
    wait_level("bnd_rise", 1'b1, 12, 6);
    observe(13);
    drive(1'b1);
    observe(12);
    check("bnd_short_at", first_sh, 7);
    check("bnd_short_cnt", obs_sh, 1);
    check("bnd_long_cnt", obs_lo, 0);

    // Back in IDLE: a new hold reaches HELD, then reset hits mid-HELD.
    drive(1'b0);
    wait_level("held_rise", 1'b1, 12, 6);
    observe(27);
    check("held_long_at", first_lo, 20);
    @(posedge clk);
    #2;
    check("held_tick_before_rst", repeat_tick, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_pressed", pressed, 0);
    check("async_rst_repeat", repeat_tick, 0);
    check("async_rst_long", long_press, 0);
    check("async_rst_short", short_press, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_level("post_rst_rise", 1'b1, 12, 6);
    observe(25);
    check("post_rst_long_at", first_lo, 20);
    check("post_rst_short_cnt", obs_sh, 0);
    check("post_rst_rep_cnt", obs_rp, 0);
    drive(1'b1);
    observe(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
